// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write scheduler.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Hard-wired zero register: never reserved, never written.
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  // One writeback request: destination register and the value to store.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter. The requester that was not granted last
// wins a tie; a lone valid request is granted at once.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  // 1 means requester 1 was granted most recently, so requester 0 wins a tie.
  logic lastGrant;

  // Grants are combinational from the valids and the pointer; none in reset.
  always_comb begin
    grant0 = rst & valid0 & (~valid1 | lastGrant);
    grant1 = rst & valid1 & (~valid0 | ~lastGrant);
  end

  // Pointer follows the requester that was just granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastGrant <= 1'b1;
    end else if (grant0) begin
      lastGrant <= 1'b0;
    end else if (grant1) begin
      lastGrant <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register file's single write port between the ALU and LSU
// writeback paths and keeps a busy scoreboard of reserved destinations.
//
// Handshake: every valid/ready pair transfers on a rising edge where both are
// high. Ready never depends on data, may rise without valid (resReady) and is
// held low while reset is asserted. A requester keeps its payload stable
// while valid is high and ready is low.
module regfile_write_scheduler
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                resValid,
  input  logic [ADDR_W-1:0]   resAddress,
  output logic                resReady,
  input  logic                req0Valid,
  input  logic [ADDR_W-1:0]   req0Address,
  input  logic [DATA_W-1:0]   req0Data,
  output logic                req0Ready,
  input  logic                req1Valid,
  input  logic [ADDR_W-1:0]   req1Address,
  input  logic [DATA_W-1:0]   req1Data,
  output logic                req1Ready,
  output logic                writeEnable,
  output logic [ADDR_W-1:0]   addressWrite,
  output logic [DATA_W-1:0]   dataWrite,
  input  logic [ADDR_W-1:0]   lookA,
  input  logic [ADDR_W-1:0]   lookB,
  output logic                busyA,
  output logic                busyB,
  output logic [NUM_REGS-1:0] busyVec
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] setVec;
  logic [NUM_REGS-1:0] clearVec;
  logic                grant0;
  logic                grant1;
  logic                anyGrant;
  wb_req_t             granted;

  rr_arbiter2 arb (
    .clk    (clk),
    .rst    (rst),
    .valid0 (req0Valid),
    .valid1 (req1Valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  // Select the winning request's payload and drive the ready outputs.
  always_comb begin
    req0Ready    = grant0;
    req1Ready    = grant1;
    anyGrant     = grant0 | grant1;
    granted.addr = grant1 ? req1Address : req0Address;
    granted.data = grant1 ? req1Data    : req0Data;
  end

  // Scoreboard updates: the write leaving the output register clears its
  // address; an accepted reservation sets its address. Clearing the same
  // address frees it for re-reservation in the same cycle.
  always_comb begin
    clearVec = '0;
    if (writeEnable) begin
      clearVec[addressWrite] = 1'b1;
    end
    resReady = rst & ((resAddress == ZERO_REG) | ~busy[resAddress] | clearVec[resAddress]);
    setVec = '0;
    if (resValid && resReady && (resAddress != ZERO_REG)) begin
      setVec[resAddress] = 1'b1;
    end
  end

  // Busy bits: set wins over clear for the same register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clearVec) | setVec;
    end
  end

  // Output register towards the register file; writes to r0 are swallowed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      writeEnable  <= 1'b0;
      addressWrite <= '0;
      dataWrite    <= '0;
    end else begin
      writeEnable <= anyGrant && (granted.addr != ZERO_REG);
      if (anyGrant) begin
        addressWrite <= granted.addr;
        dataWrite    <= granted.data;
      end
    end
  end

  // Source-operand lookups; busy[0] is never set so r0 always reads free.
  always_comb begin
    busyA   = busy[lookA];
    busyB   = busy[lookB];
    busyVec = busy;
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: directed scenarios plus
// randomized traffic compared against a transaction-level reference model.
module tb_regfile_write_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        resValid = 1'b0;
  logic [4:0]  resAddress = '0;
  logic        resReady;
  logic        req0Valid = 1'b0;
  logic [4:0]  req0Address = '0;
  logic [31:0] req0Data = '0;
  logic        req0Ready;
  logic        req1Valid = 1'b0;
  logic [4:0]  req1Address = '0;
  logic [31:0] req1Data = '0;
  logic        req1Ready;
  logic        writeEnable;
  logic [4:0]  addressWrite;
  logic [31:0] dataWrite;
  logic [4:0]  lookA = '0;
  logic [4:0]  lookB = '0;
  logic        busyA;
  logic        busyB;
  logic [31:0] busyVec;

  regfile_write_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .resValid     (resValid),
    .resAddress   (resAddress),
    .resReady     (resReady),
    .req0Valid    (req0Valid),
    .req0Address  (req0Address),
    .req0Data     (req0Data),
    .req0Ready    (req0Ready),
    .req1Valid    (req1Valid),
    .req1Address  (req1Address),
    .req1Data     (req1Data),
    .req1Ready    (req1Ready),
    .writeEnable  (writeEnable),
    .addressWrite (addressWrite),
    .dataWrite    (dataWrite),
    .lookA        (lookA),
    .lookB        (lookB),
    .busyA        (busyA),
    .busyB        (busyB),
    .busyVec      (busyVec)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: reserved registers, which requester is owed the next
  // tie, and the register-file writes expected one cycle after each grant.
  bit          busyM[32];
  int          lastWinner;
  logic [36:0] expQ[$];

  int errCount = 0;
  int chkCount = 0;

  // Observations captured by the most recent cycle for directed checks.
  logic        obsR0, obsR1, obsRes, obsBusyA, obsBusyB, obsWe;
  logic [4:0]  obsAddr;
  logic [31:0] obsVec;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) busyM[i] = 1'b0;
    lastWinner = 1;
    expQ.delete();
  endtask

  // One clock cycle: drive at the falling edge, check outputs against the
  // model, then advance the model at the rising edge.
  task automatic cycle(input logic rv, input logic [4:0] ra,
                       input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] la, input logic [4:0] lb);
    bit          g0, g1, rOk, commit;
    logic [36:0] head;
    logic [4:0]  commitAddr;
    logic [31:0] vecM;
    @(negedge clk);
    resValid = rv; resAddress = ra;
    req0Valid = v0; req0Address = a0; req0Data = d0;
    req1Valid = v1; req1Address = a1; req1Data = d1;
    lookA = la; lookB = lb;
    #1;
    if (v0 && v1) begin
      g0 = (lastWinner == 1);
      g1 = !g0;
    end else begin
      g0 = v0;
      g1 = v1;
    end
    commit = (expQ.size() != 0);
    head = commit ? expQ[0] : 37'd0;
    commitAddr = head[36:32];
    rOk = (ra == 5'd0) || !busyM[ra] || (commit && commitAddr == ra);
    for (int i = 0; i < 32; i++) vecM[i] = busyM[i];

    obsR0 = req0Ready; obsR1 = req1Ready; obsRes = resReady;
    obsBusyA = busyA; obsBusyB = busyB; obsWe = writeEnable;
    obsAddr = addressWrite; obsVec = busyVec;

    check("req0Ready", {31'd0, req0Ready}, {31'd0, g0});
    check("req1Ready", {31'd0, req1Ready}, {31'd0, g1});
    check("resReady", {31'd0, resReady}, {31'd0, rOk});
    check("busyA", {31'd0, busyA}, {31'd0, busyM[la]});
    check("busyB", {31'd0, busyB}, {31'd0, busyM[lb]});
    check("busyVec", busyVec, vecM);
    check("writeEnable", {31'd0, writeEnable}, {31'd0, commit});
    if (commit) begin
      check("addressWrite", {27'd0, addressWrite}, {27'd0, commitAddr});
      check("dataWrite", dataWrite, head[31:0]);
    end

    @(posedge clk);
    if (commit) begin
      busyM[commitAddr] = 1'b0;
      void'(expQ.pop_front());
    end
    if (rv && rOk && ra != 5'd0) busyM[ra] = 1'b1;
    if (g0) begin
      if (a0 != 5'd0) expQ.push_back({a0, d0});
      lastWinner = 0;
    end else if (g1) begin
      if (a1 != 5'd0) expQ.push_back({a1, d1});
      lastWinner = 1;
    end
  endtask

  task automatic idle(input logic [4:0] la, input logic [4:0] lb);
    cycle(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, la, lb);
  endtask

  task automatic reserve(input logic [4:0] ra, input logic [4:0] la);
    cycle(1'b1, ra, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, la, 5'd0);
  endtask

  initial begin
    modelReset();

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_busyVec", busyVec, 32'd0);
    check("rst_we", {31'd0, writeEnable}, 32'd0);
    check("rst_addr", {27'd0, addressWrite}, 32'd0);
    check("rst_data", dataWrite, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Contention: grants alternate 0,1,0,1; writes stream back to back
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 5'd0, 1'b1, 5'd3, 32'h1111 + i, 1'b1, 5'd4, 32'h2222 + i, 5'd0, 5'd0);
      check("cont_grant0", {31'd0, obsR0}, {31'd0, (i % 2 == 0)});
      if (i > 0) check("cont_we", {31'd0, obsWe}, 32'd1);
    end

    // Reserve then write r5
    reserve(5'd5, 5'd5);
    reserve(5'd5, 5'd5);
    check("res_busyA", {31'd0, obsBusyA}, 32'd1);
    check("res_waw", {31'd0, obsRes}, 32'd0);
    cycle(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
    idle(5'd5, 5'd0);
    check("res_we", {31'd0, obsWe}, 32'd1);
    check("res_addr", {27'd0, obsAddr}, 32'd5);
    idle(5'd5, 5'd0);
    check("res_cleared", {31'd0, obsBusyA}, 32'd0);

    // Reservation of r7 while its committed write clears it
    reserve(5'd7, 5'd0);
    cycle(1'b0, 5'd0, 1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    reserve(5'd7, 5'd7);
    check("coll_resReady", {31'd0, obsRes}, 32'd1);
    idle(5'd7, 5'd0);
    check("coll_busy7", {31'd0, obsBusyA}, 32'd1);

    // Mid-stream reset with busy = 0xF0 and a grant pending
    for (int r = 4; r < 8; r++) reserve(r[4:0], 5'd0);
    cycle(1'b0, 5'd0, 1'b1, 5'd3, 32'hABCD, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("pre_rst_vec", obsVec, 32'h0000_00F0);
    #2;
    rst = 1'b0;
    resValid = 1'b1; resAddress = 5'd9; req0Valid = 1'b1; req1Valid = 1'b1;
    #1;
    check("mid_rst_vec", busyVec, 32'd0);
    check("mid_rst_we", {31'd0, writeEnable}, 32'd0);
    check("mid_rst_addr", {27'd0, addressWrite}, 32'd0);
    check("mid_rst_data", dataWrite, 32'd0);
    check("mid_rst_rdy", {29'd0, req0Ready, req1Ready, resReady}, 32'd0);
    @(negedge clk);
    resValid = 1'b0; req0Valid = 1'b0; req1Valid = 1'b0;
    @(negedge clk);
    check("rst_hold_we", {31'd0, writeEnable}, 32'd0);
    rst = 1'b1;
    modelReset();
    #1;
    check("post_rst_addr", {27'd0, addressWrite}, 32'd0);
    check("post_rst_data", dataWrite, 32'd0);
    idle(5'd0, 5'd0);
    check("post_rst_nowrite", {31'd0, obsWe}, 32'd0);

    // Zero register write and reservation
    cycle(1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("zero_req0Ready", {31'd0, obsR0}, 32'd1);
    check("zero_resReady", {31'd0, obsRes}, 32'd1);
    check("zero_busyB", {31'd0, obsBusyB}, 32'd0);
    idle(5'd0, 5'd0);
    check("zero_we", {31'd0, obsWe}, 32'd0);
    check("zero_busy0", {31'd0, obsVec[0]}, 32'd0);

    // Lone requester 1 for three cycles, then a tie goes to requester 0
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9 + i[4:0], 32'h900 + i, 5'd0, 5'd0);
      check("lone_grant1", {31'd0, obsR1}, 32'd1);
      if (i > 0) check("lone_we", {31'd0, obsWe}, 32'd1);
    end
    cycle(1'b0, 5'd0, 1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0, 5'd0, 5'd0);
    check("lone_tie0", {31'd0, obsR0}, 32'd1);
    check("lone_we3", {31'd0, obsWe}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 1), 5'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 15)), $urandom,
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);

    $display("Result: errors=%0d of %0d checks", errCount, chkCount);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Schedules the single write port of the 32 x 32-bit register file between two writeback requesters (ALU and load/store unit) and tracks pending writes in a busy scoreboard. The issue stage reserves a destination register before dispatch. Read-side lookups report whether a source register still awaits its write so the pipeline can stall. Sits between the writeback stage and the register file's `writeEnable`/`addressWrite`/`dataWrite` port.

## Interface
- `DATA_W`, 32: writeback data width.
- `ADDR_W`, 5: register address width; `NUM_REGS` = 2**ADDR_W.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `resValid` in 1: issue stage requests reservation of `resAddress`.
- `resAddress` in ADDR_W: destination register to reserve.
- `resReady` out 1: reservation accepted this cycle.
- `req0Valid`, `req1Valid` in 1: writeback request from ALU (0) / LSU (1).
- `req0Address`, `req1Address` in ADDR_W: destination of the writeback.
- `req0Data`, `req1Data` in DATA_W: writeback data.
- `req0Ready`, `req1Ready` out 1: request granted (transfer when valid & ready).
- `writeEnable` out 1: to register file.
- `addressWrite` out ADDR_W: to register file.
- `dataWrite` out DATA_W: to register file.
- `lookA`, `lookB` in ADDR_W: source registers of the instruction in decode.
- `busyA`, `busyB` out 1: source register has a pending write.
- `busyVec` out NUM_REGS: full scoreboard, for debug.

## Operation
- **Scoreboard.** One busy bit per register.
  - Set by an accepted reservation.
  - Cleared in the cycle `writeEnable` is asserted for that address.
- **Reservation.** `resReady` = !busy[resAddress] | (clearing same address this cycle). This blocks WAW double reservation.
  - Address 0 is never reserved: `resReady` is 1 and busy[0] stays 0.
- **Arbitration.** Two-way round robin over valid requests.
  - Pointer `lastGrant` (reset 1, so req0 wins the first tie) flips to the granted requester after each grant.
  - A lone valid request is granted immediately.
  - At most one grant per cycle. Ready is combinational from valid and `lastGrant`.
- **Output register.** The granted {address, data} is registered; `writeEnable` = 1 the following cycle.
  - A granted write to address 0 is accepted (ready=1) but produces `writeEnable` = 0.
- **Simultaneous events.**
  - Reservation and clear of the same address in one cycle: result is busy=1 (set wins).
  - Reservation and clear of different addresses: both apply.
- **Unreserved writes.** A writeback to a non-busy address is still written; busy stays 0.
- **Lookup.** `busyA` = busy[lookA], `busyB` = busy[lookB], combinational. Address 0 always returns 0.
- **Reset (rst = 0).** All busy bits 0; `writeEnable` 0; `addressWrite`/`dataWrite` 0; `lastGrant` 1.
  - In-flight grants are discarded.
  - Ready outputs are 0 while reset is asserted.

## Timing
- Grant to register-file write latency: 1 cycle. The write lands at the edge ending the `writeEnable` cycle.
- Reservation accepted at edge N: `busyA` reflects it from cycle N+1.
- Write committed: busy clears at the same edge the register file captures the data. `busyA` is 0 in the following cycle, so a dependent read sees new data with no extra bubble.
- Throughput: one write per cycle sustained. Each requester gets at least one grant in every two cycles under contention.
- Reset deassertion is synchronous to `clk` at the system level. First grant is possible in the first cycle after release.

## Structure
- Shared package `regfile_pkg`:
  - `DATA_W`, `ADDR_W`, `NUM_REGS`.
  - `ZERO_REG` = 0.
  - Typedef `wb_req_t` {addr, data}.
- Sub-module `rr_arbiter2`:
  - Ports: two valids in, two grants out, `lastGrant` state.
  - Async active-low reset.
- The top holds the scoreboard, output register and reservation logic.

## Test plan
- **Reset.** Reset mid-stream with busy = 0x0000_00F0 and a grant pending. Required: busyVec = 0, `writeEnable` = 0, `addressWrite`/`dataWrite` = 0 during and after reset; the pending write never reaches the file.
- **Contention.** req0 (r3, 0x1111) and req1 (r4, 0x2222) valid for 4 cycles with new data each cycle. Required: grants alternate 0,1,0,1; one `writeEnable` per cycle starting one cycle after the first grant.
- **Reserve then write.** Reserve r5; `busyA` (lookA = 5) = 1 next cycle; `resReady` = 0 for a second r5 reservation. Then req1 writes r5 = 0xDEAD_BEEF. Required: `writeEnable` with address 5; `busyA` = 0 the following cycle.
- **Same-address collision.** Reserve r7 in the cycle a committed write clears r7. Required: `resReady` = 1 and busy[7] = 1 afterwards.
- **Zero register.** req0 writes r0 = 0xFFFF_FFFF and reserve r0. Required: req0Ready = 1, `writeEnable` stays 0, `resReady` = 1, busy[0] = 0, `busyB` (lookB = 0) = 0.
- **Lone request.** Only req1 valid for 3 cycles (r9, r10, r11). Required: granted every cycle with no idle cycle; `lastGrant` = 1 afterwards, so req0 wins the next tie.
